id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register with integrated load-use hazard detection.
- Captures decoded operands and control from ID each cycle and presents them to EX, including EX_rs/EX_rt for the forwarding unit.
- Inserts a single-cycle bubble on a load-use hazard and holds PC/IF-ID via Stall.
- Squashes the ID instruction on a taken-branch Flush and keeps a saturating stall counter for performance analysis.

Parameters:
- DW, 32, datapath width (operands, immediate, PC+4)
- CNT_W, 16, width of stall counter

Ports:
- CLK  in  1  clock, all state updates on rising edge
- Reset  in  1  asynchronous, active-low; clears all state immediately
- Flush  in  1  taken branch/jump resolved in EX; squash instruction in ID
- ID_rs  in  5  rs field of ID instruction
- ID_rt  in  5  rt field of ID instruction
- ID_rd  in  5  rd field of ID instruction
- ID_UsesRt  in  1  ID instruction reads rt as a source operand
- ID_ReadData1  in  DW  register file port 1
- ID_ReadData2  in  DW  register file port 2
- ID_Imm32  in  DW  extended immediate
- ID_PC4  in  DW  PC+4 of ID instruction
- ID_RegWre  in  1  register write enable
- ID_MemRead  in  1  load instruction
- ID_MemWre  in  1  store instruction
- ID_ALUSrcA  in  1  ALU A source select
- ID_ALUSrcB  in  1  ALU B source select
- ID_ALUOp  in  3  ALU operation
- ID_RegDst  in  2  destination select (00 rt, 01 rd, 10 $31)
- EX_rs, EX_rt, EX_rd  out  5  registered register fields
- EX_ReadData1, EX_ReadData2, EX_Imm32, EX_PC4  out  DW  registered data
- EX_RegWre, EX_MemRead, EX_MemWre, EX_ALUSrcA, EX_ALUSrcB  out  1  registered control
- EX_ALUOp  out  3  registered control
- EX_RegDst  out  2  registered control
- Stall  out  1  combinational; hold PC and IF/ID this cycle
- StallCount  out  CNT_W  saturating count of bubbles inserted

Behaviour:
- Reset low (asynchronous): every EX_* output is 0 and StallCount is 0, i.e. a NOP in EX. Stall is then 0 because EX_MemRead is 0.
- Hazard (combinational, same cycle):
  - Hazard = EX_MemRead & (EX_rt != 0) & ((EX_rt == ID_rs) | (ID_UsesRt & EX_rt == ID_rt)).
  - Stall = Hazard & ~Flush.
- Register update on each rising edge, in priority order:
  1. Flush=1: load bubble (all EX_* = 0). Flush has priority over Hazard. Stall stays 0, so the PC takes the branch target.
  2. Hazard=1: load bubble (all EX_* = 0). StallCount increments.
  3. Otherwise: every EX_* takes its ID_* value. Latency is 1 cycle.
- Bubble duration: a bubble clears EX_MemRead, so Hazard drops the next cycle. Each load-use stall therefore lasts exactly one cycle, with no state machine beyond the register contents. The previous ID instruction, held by upstream, is captured on the following edge.
- StallCount:
  - Increments only on a hazard bubble, not on a Flush bubble.
  - Saturates at 2^CNT_W-1 (no wrap).
  - Cleared only by Reset.
- $0 rule: a load to $0 (EX_rt=0) never stalls.
- Store source: a load followed by a store that uses the loaded reg as data (ID_UsesRt=1) stalls. With ID_UsesRt=0, an rt match is ignored.
- Reset asserted mid-stall: outputs clear immediately. Stall deasserts in the same delta because EX_MemRead goes to 0.
- No X on outputs after reset. All inputs are sampled only at the edge, except for the combinational Stall.

Test Plan:
- Reset: hold Reset=0 with random ID inputs, then release.
  -> All EX_* are 0, StallCount=0, Stall=0. Then after one edge EX_* equals the ID_* values (e.g. ID_rs=3 gives EX_rs=3, ID_ReadData1=32'h1234 gives EX_ReadData1=32'h1234).
- Load-use on rs: EX holds lw with EX_MemRead=1, EX_rt=5; ID_rs=5.
  -> Stall=1 immediately. The next edge gives EX_RegWre=0, EX_MemRead=0, StallCount=1, and Stall=0 in the following cycle.
- Load-use on rt: EX_rt=4, ID_rt=4.
  -> With ID_UsesRt=0: Stall=0, ID captured normally.
  -> With ID_UsesRt=1: Stall=1 and a bubble is inserted.
- $0 and Flush priority: EX_MemRead=1, EX_rt=0, ID_rs=0.
  -> Stall=0.
  - Then EX_rt=7, ID_rs=7, Flush=1.
  -> Stall=0, bubble loaded, StallCount unchanged.
- Saturation: CNT_W=2, force 5 hazard bubbles.
  -> StallCount reads 1, 2, 3, 3, 3.
- Async reset mid-operation: pulse Reset low between edges while EX_MemRead=1.
  -> All outputs clear without a clock edge, and Stall=0.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - ID-side inputs and EX-side outputs of the ID/EX pipeline register
interface id_ex_stage_if #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
);
  logic             Flush;
  logic [4:0]       ID_rs;
  logic [4:0]       ID_rt;
  logic [4:0]       ID_rd;
  logic             ID_UsesRt;
  logic [DW-1:0]    ID_ReadData1;
  logic [DW-1:0]    ID_ReadData2;
  logic [DW-1:0]    ID_Imm32;
  logic [DW-1:0]    ID_PC4;
  logic             ID_RegWre;
  logic             ID_MemRead;
  logic             ID_MemWre;
  logic             ID_ALUSrcA;
  logic             ID_ALUSrcB;
  logic [2:0]       ID_ALUOp;
  logic [1:0]       ID_RegDst;

  logic [4:0]       EX_rs;
  logic [4:0]       EX_rt;
  logic [4:0]       EX_rd;
  logic [DW-1:0]    EX_ReadData1;
  logic [DW-1:0]    EX_ReadData2;
  logic [DW-1:0]    EX_Imm32;
  logic [DW-1:0]    EX_PC4;
  logic             EX_RegWre;
  logic             EX_MemRead;
  logic             EX_MemWre;
  logic             EX_ALUSrcA;
  logic             EX_ALUSrcB;
  logic [2:0]       EX_ALUOp;
  logic [1:0]       EX_RegDst;
  logic             Stall;
  logic [CNT_W-1:0] StallCount;

  modport master (
    output Flush, ID_rs, ID_rt, ID_rd, ID_UsesRt, ID_ReadData1, ID_ReadData2, ID_Imm32, ID_PC4,
           ID_RegWre, ID_MemRead, ID_MemWre, ID_ALUSrcA, ID_ALUSrcB, ID_ALUOp, ID_RegDst,
    input  EX_rs, EX_rt, EX_rd, EX_ReadData1, EX_ReadData2, EX_Imm32, EX_PC4,
           EX_RegWre, EX_MemRead, EX_MemWre, EX_ALUSrcA, EX_ALUSrcB, EX_ALUOp, EX_RegDst,
           Stall, StallCount
  );

  modport slave (
    input  Flush, ID_rs, ID_rt, ID_rd, ID_UsesRt, ID_ReadData1, ID_ReadData2, ID_Imm32, ID_PC4,
           ID_RegWre, ID_MemRead, ID_MemWre, ID_ALUSrcA, ID_ALUSrcB, ID_ALUOp, ID_RegDst,
    output EX_rs, EX_rt, EX_rd, EX_ReadData1, EX_ReadData2, EX_Imm32, EX_PC4,
           EX_RegWre, EX_MemRead, EX_MemWre, EX_ALUSrcA, EX_ALUSrcB, EX_ALUOp, EX_RegDst,
           Stall, StallCount
  );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard detection and stall counter
module id_ex_stage #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic          CLK,
  input  logic          Reset,
  id_ex_stage_if.slave  bus
);
  typedef struct packed {
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic [DW-1:0] readData1;
    logic [DW-1:0] readData2;
    logic [DW-1:0] imm32;
    logic [DW-1:0] pc4;
    logic          regWre;
    logic          memRead;
    logic          memWre;
    logic          aluSrcA;
    logic          aluSrcB;
    logic [2:0]    aluOp;
    logic [1:0]    regDst;
  } exRegT;

  exRegT            exReg;
  exRegT            idIn;
  logic             hazard;
  logic [CNT_W-1:0] stallCount;

  assign idIn = {bus.ID_rs, bus.ID_rt, bus.ID_rd,
                 bus.ID_ReadData1, bus.ID_ReadData2, bus.ID_Imm32, bus.ID_PC4,
                 bus.ID_RegWre, bus.ID_MemRead, bus.ID_MemWre,
                 bus.ID_ALUSrcA, bus.ID_ALUSrcB, bus.ID_ALUOp, bus.ID_RegDst};

  // A load in EX writing a register the ID instruction reads; $0 is never a real dependency.
  always_comb begin
    hazard = exReg.memRead && (exReg.rt != 5'd0) &&
             ((exReg.rt == bus.ID_rs) || (bus.ID_UsesRt && (exReg.rt == bus.ID_rt)));
  end

  assign bus.Stall = hazard & ~bus.Flush;

  // The bubble clears memRead, so a load-use stall ends after one cycle by construction.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      exReg      <= '0;
      stallCount <= '0;
    end else if (bus.Flush) begin
      exReg <= '0;
    end else if (hazard) begin
      exReg <= '0;
      if (stallCount != {CNT_W{1'b1}}) begin
        stallCount <= stallCount + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      exReg <= idIn;
    end
  end

  assign bus.EX_rs        = exReg.rs;
  assign bus.EX_rt        = exReg.rt;
  assign bus.EX_rd        = exReg.rd;
  assign bus.EX_ReadData1 = exReg.readData1;
  assign bus.EX_ReadData2 = exReg.readData2;
  assign bus.EX_Imm32     = exReg.imm32;
  assign bus.EX_PC4       = exReg.pc4;
  assign bus.EX_RegWre    = exReg.regWre;
  assign bus.EX_MemRead   = exReg.memRead;
  assign bus.EX_MemWre    = exReg.memWre;
  assign bus.EX_ALUSrcA   = exReg.aluSrcA;
  assign bus.EX_ALUSrcB   = exReg.aluSrcB;
  assign bus.EX_ALUOp     = exReg.aluOp;
  assign bus.EX_RegDst    = exReg.regDst;
  assign bus.StallCount   = stallCount;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage
module tb_id_ex_stage;
  logic CLK;
  logic Reset;

  id_ex_stage_if #(.DW(32), .CNT_W(16)) bus ();
  id_ex_stage_if #(.DW(32), .CNT_W(2))  bus2 ();

  id_ex_stage #(.DW(32), .CNT_W(16)) dut  (.CLK(CLK), .Reset(Reset), .bus(bus));
  id_ex_stage #(.DW(32), .CNT_W(2))  dut2 (.CLK(CLK), .Reset(Reset), .bus(bus2));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [4:0]  rs, rt, rd;
    logic        usesRt;
    logic [31:0] rd1, rd2, imm, pc4;
    logic        regWre, memRead, memWre, srcA, srcB;
    logic [2:0]  aluOp;
    logic [1:0]  regDst;
  } idVecT;

  typedef struct packed {
    logic [4:0]  rs, rt, rd;
    logic [31:0] rd1, rd2, imm, pc4;
    logic        regWre, memRead, memWre, srcA, srcB;
    logic [2:0]  aluOp;
    logic [1:0]  regDst;
  } exT;

  typedef struct {
    logic        stall;
    exT          ex;
    logic [15:0] cnt;
  } expT;

  expT sbq[$];
  int  nRun  = 0;
  int  nFail = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    nRun++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic idVecT mk(input int tag, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic usesRt, input logic regWre,
                               input logic memRead, input logic memWre);
    idVecT v;
    v.rs = rs; v.rt = rt; v.rd = rd; v.usesRt = usesRt;
    v.rd1 = 32'h1230 + tag;
    v.rd2 = 32'hB000_0000 + tag;
    v.imm = 32'hC000 + tag;
    v.pc4 = 32'h400 + 4 * tag;
    v.regWre = regWre; v.memRead = memRead; v.memWre = memWre;
    v.srcA = tag[0]; v.srcB = tag[1]; v.aluOp = tag[2:0]; v.regDst = tag[1:0];
    return v;
  endfunction

  function automatic exT toEx(input idVecT v);
    return {v.rs, v.rt, v.rd, v.rd1, v.rd2, v.imm, v.pc4,
            v.regWre, v.memRead, v.memWre, v.srcA, v.srcB, v.aluOp, v.regDst};
  endfunction

  function automatic exT actEx();
    return {bus.EX_rs, bus.EX_rt, bus.EX_rd, bus.EX_ReadData1, bus.EX_ReadData2, bus.EX_Imm32,
            bus.EX_PC4, bus.EX_RegWre, bus.EX_MemRead, bus.EX_MemWre, bus.EX_ALUSrcA,
            bus.EX_ALUSrcB, bus.EX_ALUOp, bus.EX_RegDst};
  endfunction

  task automatic drive(input idVecT v, input logic fl);
    bus.Flush = fl;
    bus.ID_rs = v.rs; bus.ID_rt = v.rt; bus.ID_rd = v.rd; bus.ID_UsesRt = v.usesRt;
    bus.ID_ReadData1 = v.rd1; bus.ID_ReadData2 = v.rd2; bus.ID_Imm32 = v.imm; bus.ID_PC4 = v.pc4;
    bus.ID_RegWre = v.regWre; bus.ID_MemRead = v.memRead; bus.ID_MemWre = v.memWre;
    bus.ID_ALUSrcA = v.srcA; bus.ID_ALUSrcB = v.srcB; bus.ID_ALUOp = v.aluOp; bus.ID_RegDst = v.regDst;
  endtask

  task automatic drive2(input idVecT v);
    bus2.Flush = 1'b0;
    bus2.ID_rs = v.rs; bus2.ID_rt = v.rt; bus2.ID_rd = v.rd; bus2.ID_UsesRt = v.usesRt;
    bus2.ID_ReadData1 = v.rd1; bus2.ID_ReadData2 = v.rd2; bus2.ID_Imm32 = v.imm; bus2.ID_PC4 = v.pc4;
    bus2.ID_RegWre = v.regWre; bus2.ID_MemRead = v.memRead; bus2.ID_MemWre = v.memWre;
    bus2.ID_ALUSrcA = v.srcA; bus2.ID_ALUSrcB = v.srcB; bus2.ID_ALUOp = v.aluOp; bus2.ID_RegDst = v.regDst;
  endtask

  task automatic push(input logic expStall, input logic bubble, input idVecT v, input int expCnt);
    expT e;
    e.stall = expStall;
    e.ex    = bubble ? '0 : toEx(v);
    e.cnt   = expCnt[15:0];
    sbq.push_back(e);
  endtask

  task automatic step(input idVecT v, input logic fl, input logic expStall, input logic bubble,
                      input int expCnt);
    @(negedge CLK);
    drive(v, fl);
    push(expStall, bubble, v, expCnt);
  endtask

  // Monitor: Stall is checked just before the edge, registered outputs just after it.
  initial begin
    expT e;
    forever begin
      @(negedge CLK);
      #4;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("stall", {159'b0, bus.Stall}, {159'b0, e.stall});
        @(posedge CLK);
        #1;
        chk("ex_regs", {7'b0, actEx()}, {7'b0, e.ex});
        chk("stall_count", {144'b0, bus.StallCount}, {144'b0, e.cnt});
      end
    end
  end

  initial begin
    idVecT v1, v2, v3, v4, v5, v6, v7, v8, v9, v10, z, ld, use2;
    v1  = mk(4,  5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    v2  = mk(5,  5'd1, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    v3  = mk(6,  5'd5, 5'd6, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    v4  = mk(7,  5'd2, 5'd4, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    v5  = mk(8,  5'd8, 5'd4, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
    v6  = mk(9,  5'd8, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    v7  = mk(10, 5'd9, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    v8  = mk(11, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    v9  = mk(12, 5'd2, 5'd7, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    v10 = mk(13, 5'd7, 5'd1, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    z   = '0;
    ld  = mk(20, 5'd1, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    use2 = mk(21, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);

    Reset = 1'b0;
    drive2(z);
    repeat (3) begin
      @(negedge CLK);
      drive(idVecT'({$urandom, $urandom, $urandom, $urandom, $urandom}), 1'b0);
    end
    #1;
    chk("reset_ex", {7'b0, actEx()}, 160'b0);
    chk("reset_count", {144'b0, bus.StallCount}, 160'b0);
    chk("reset_stall", {159'b0, bus.Stall}, 160'b0);

    @(negedge CLK);
    Reset = 1'b1;
    drive(v1, 1'b0);
    push(1'b0, 1'b0, v1, 0);

    step(v2,  1'b0, 1'b0, 1'b0, 0);   // lw with rt=5
    step(v3,  1'b0, 1'b1, 1'b1, 1);   // rs=5 uses the load: bubble
    step(v3,  1'b0, 1'b0, 1'b0, 1);   // held instruction captured
    step(v4,  1'b0, 1'b0, 1'b0, 1);   // lw with rt=4
    step(v5,  1'b0, 1'b0, 1'b0, 1);   // rt match ignored when rt is not a source
    step(v4,  1'b0, 1'b0, 1'b0, 1);
    step(v6,  1'b0, 1'b1, 1'b1, 2);   // store data from loaded reg: bubble
    step(v6,  1'b0, 1'b0, 1'b0, 2);
    step(v7,  1'b0, 1'b0, 1'b0, 2);   // lw to $0
    step(v8,  1'b0, 1'b0, 1'b0, 2);   // rs=0 never stalls
    step(v9,  1'b0, 1'b0, 1'b0, 2);   // lw with rt=7
    step(v10, 1'b1, 1'b0, 1'b1, 2);   // flush wins over hazard, count unchanged
    step(v10, 1'b0, 1'b0, 1'b0, 2);
    step(v9,  1'b0, 1'b0, 1'b0, 2);

    @(posedge CLK);
    #2;
    bus.ID_rs = 5'd7;
    #1;
    chk("pre_reset_stall", {159'b0, bus.Stall}, {159'b0, 1'b1});
    Reset = 1'b0;
    #1;
    chk("async_reset_ex", {7'b0, actEx()}, 160'b0);
    chk("async_reset_stall", {159'b0, bus.Stall}, 160'b0);
    chk("async_reset_count", {144'b0, bus.StallCount}, 160'b0);
    @(negedge CLK);
    Reset = 1'b1;
    drive(z, 1'b0);

    @(negedge CLK);
    drive2(ld);
    @(negedge CLK);
    drive2(use2);
    for (int i = 0; i < 5; i++) begin
      logic [1:0] expSat;
      expSat = (i >= 2) ? 2'd3 : 2'(i + 1);
      @(posedge CLK);
      #1;
      chk($sformatf("sat_count_%0d", i), {158'b0, bus2.StallCount}, {158'b0, expSat});
      @(posedge CLK);
      #1;
      chk($sformatf("sat_capture_%0d", i), {159'b0, bus2.EX_MemRead}, {159'b0, 1'b1});
    end

    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge CLK);
    if (sbq.size() > 0) begin
      nRun++;
      nFail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", nRun, nFail);
    $finish;
  end
endmodule
